// File: rtl/rv32i_types.sv
// Shared types for the unified memory port arbiter.
// Holds the FSM state encoding, the port identifier and the captured-request record.
// A small helper tells whether a request record carries any active mask.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } arb_port_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_req_t;

    localparam logic [3:0] MASK_NONE = 4'h0;

    // A request is present whenever either mask is nonzero.
    function automatic logic req_active(input mem_req_t r);
        return (r.rmask != MASK_NONE) || (r.wmask != MASK_NONE);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_req_latch.sv
// Purpose: per-port pending register holding one captured memory request.
// Latency: request visible on req/pending one edge after a nonzero mask.
// Backpressure: none; the port owner must not re-request while pending or issued.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_in        raw CPU-side request (addr, masks, wdata)
//   clear         grant strobe from the arbiter, drops the pending flag
//   req           latched request record
//   pending       request waiting for a grant
module arb_req_latch
    import rv32i_types::*;
(
    input  logic     clk,
    input  logic     rst,
    input  mem_req_t req_in,
    input  logic     clear,
    output mem_req_t req,
    output logic     pending
);

    logic set;

    assign set = req_active(req_in);

    // Capture has priority over clear. A capture coinciding with this port's
    // own grant cannot happen legally (the port is still busy), so letting the
    // newer request win only matters for protocol violations, where keeping
    // the request is the safer outcome.
    always_ff @(posedge clk) begin
        if (rst) begin
            req     <= '0;
            pending <= 1'b0;
        end else if (set) begin
            req     <= req_in;
            pending <= 1'b1;
        end else if (clear) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between the fetch (imem) and data (dmem) CPU ports.
// Latency: mask pulse two cycles after capture; response routed back combinationally.
// Backpressure: one transaction outstanding; requests wait in per-port pending latches.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_addr/rmask                fetch request (one-cycle nonzero mask)
//   imem_rdata/resp                fetch response
//   dmem_addr/rmask/wmask/wdata    load/store request (one-cycle nonzero mask)
//   dmem_rdata/resp                load/store response
//   mem_addr/wdata                 unified address/store data, held from issue
//   mem_rmask/wmask                unified one-cycle mask pulse
//   mem_rdata/resp                 unified response from memory
module mem_port_arbiter
    import rv32i_types::*;
#(
    parameter int ARB_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,

    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,

    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    arb_state_t state;
    arb_port_t  last_grant;

    mem_req_t   i_req_in;
    mem_req_t   d_req_in;
    mem_req_t   i_req;
    mem_req_t   d_req;
    logic       i_pending;
    logic       d_pending;

    arb_port_t  winner;
    mem_req_t   win_req;
    logic       issue;
    logic       clr_i;
    logic       clr_d;

    logic [31:0] imem_rdata_q;
    logic [31:0] dmem_rdata_q;

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    assign i_req_in = '{addr: imem_addr, rmask: imem_rmask, wmask: MASK_NONE, wdata: 32'h0};
    assign d_req_in = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};

    arb_req_latch u_i_latch (
        .clk     (clk),
        .rst     (rst),
        .req_in  (i_req_in),
        .clear   (clr_i),
        .req     (i_req),
        .pending (i_pending)
    );

    arb_req_latch u_d_latch (
        .clk     (clk),
        .rst     (rst),
        .req_in  (d_req_in),
        .clear   (clr_d),
        .req     (d_req),
        .pending (d_pending)
    );

    // ------------------------------------------------------------------
    // Winner selection. Works only from latched state, so there is no
    // combinational path from the CPU masks to the memory masks.
    // ------------------------------------------------------------------
    always_comb begin
        winner = ARB_I;
        if (d_pending && !i_pending) begin
            winner = ARB_D;
        end else if (d_pending && i_pending) begin
            if (ARB_MODE == 0) begin
                winner = ARB_D;
            end else begin
                // Round-robin: serve whichever port was not served last.
                winner = (last_grant == ARB_I) ? ARB_D : ARB_I;
            end
        end
    end

    assign win_req = (winner == ARB_D) ? d_req : i_req;
    assign issue   = (state == IDLE) && (i_pending || d_pending);
    assign clr_i   = issue && (winner == ARB_I);
    assign clr_d   = issue && (winner == ARB_D);

    // ------------------------------------------------------------------
    // Grant FSM with registered memory-side outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ARB_I;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_rmask  <= MASK_NONE;
            mem_wmask  <= MASK_NONE;
        end else begin
            // Masks are single-cycle pulses; address and data stay put.
            mem_rmask <= MASK_NONE;
            mem_wmask <= MASK_NONE;
            case (state)
                IDLE: begin
                    if (issue) begin
                        mem_addr   <= win_req.addr;
                        mem_wdata  <= win_req.wdata;
                        mem_rmask  <= win_req.rmask;
                        mem_wmask  <= win_req.wmask;
                        last_grant <= winner;
                        state      <= (winner == ARB_D) ? D_BUSY : I_BUSY;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (mem_resp) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response routing. The owner sees mem_rdata in the response cycle;
    // outside it each port keeps showing the last data it received.
    // ------------------------------------------------------------------
    assign imem_resp = (state == I_BUSY) && mem_resp;
    assign dmem_resp = (state == D_BUSY) && mem_resp;

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_rdata_q <= 32'h0;
            dmem_rdata_q <= 32'h0;
        end else begin
            if (imem_resp) begin
                imem_rdata_q <= mem_rdata;
            end
            if (dmem_resp) begin
                dmem_rdata_q <= mem_rdata;
            end
        end
    end

    assign imem_rdata = imem_resp ? mem_rdata : imem_rdata_q;
    assign dmem_rdata = dmem_resp ? mem_rdata : dmem_rdata_q;

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
    // A port may only re-request in its own response cycle.
    assert property (@(posedge clk) disable iff (rst)
        !((imem_rmask != MASK_NONE) && (i_pending || (state == I_BUSY)) && !imem_resp))
        else $error("imem request while busy");

    assert property (@(posedge clk) disable iff (rst)
        !(((dmem_rmask != MASK_NONE) || (dmem_wmask != MASK_NONE))
          && (d_pending || (state == D_BUSY)) && !dmem_resp))
        else $error("dmem request while busy");

    assert property (@(posedge clk) disable iff (rst)
        !((dmem_rmask != MASK_NONE) && (dmem_wmask != MASK_NONE)))
        else $error("dmem read and write masks both set");

    assert property (@(posedge clk) disable iff (rst)
        !((state == IDLE) && mem_resp))
        else $error("mem_resp while idle");

endmodule
